pixel_row_packer: RTL and testbench



---
 rtl/pixel_row_packer.sv | 123 ++++++++++++
 tb/tb_pixel_row_packer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_row_packer.sv
// Serial-to-parallel pixel packer: gathers NrOfBits binarised pixels into one row word
// and issues a single-cycle row-register write per row across a frame of NrOfRows rows.
// Optional per-row ones counter (RowOnes) is enabled by defining PACK_POPCOUNT_EN.
module pixel_row_packer #(
  parameter int NrOfBits = 28,
  parameter int NrOfRows = 28,
  parameter int AddrBits = 5,
  parameter int PopBits  = 5
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                FrameStart,
  input  logic                PixValid,
  input  logic                PixData,
  output logic                PixReady,
  output logic [NrOfBits-1:0] RegD,
  output logic [AddrBits-1:0] RegAddr,
  output logic                RegWe,
  output logic                FrameDone
`ifdef PACK_POPCOUNT_EN
  ,
  output logic [PopBits-1:0]  RowOnes
`endif
);

  localparam int CntW = (NrOfBits > 1) ? $clog2(NrOfBits) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CntW-1:0]     bit_cnt;
  logic [NrOfBits-1:0] shreg;
  logic                accept;
  logic                last_pix;
  logic                last_row;

  assign last_pix = (bit_cnt == CntW'(NrOfBits - 1));
  assign last_row = (RegAddr == AddrBits'(NrOfRows - 1));
  assign RegD     = shreg;

  // Next-state and state-decoded outputs; FrameStart overrides every other transition.
  always_comb begin
    state_nxt = state;
    PixReady  = 1'b0;
    RegWe     = 1'b0;
    FrameDone = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: ;
      FILL: begin
        PixReady = ~FrameStart;
        accept   = PixValid & ~FrameStart & Tick;
        if (accept && last_pix) state_nxt = COMMIT;
      end
      COMMIT: begin
        RegWe = 1'b1;
        if (Tick) state_nxt = last_row ? DONE : FILL;
      end
      DONE: FrameDone = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (Tick && FrameStart) state_nxt = FILL;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else if (Tick) begin
      state <= state_nxt;
    end
  end

  // Row datapath: shift register, bit counter and row address advance only on Tick.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      RegAddr <= '0;
    end else if (Tick) begin
      if (FrameStart) begin
        shreg   <= '0;
        bit_cnt <= '0;
        RegAddr <= '0;
      end else begin
        if (accept) begin
          shreg <= (shreg << 1) | NrOfBits'(PixData);
          if (!last_pix) bit_cnt <= bit_cnt + CntW'(1);
        end
        if (state == COMMIT && !last_row) begin
          RegAddr <= RegAddr + AddrBits'(1);
          bit_cnt <= '0;
        end
      end
    end
  end

`ifdef PACK_POPCOUNT_EN
  // Ones counter follows the bit counter's clear points so it matches RegD during COMMIT.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      RowOnes <= '0;
    end else if (Tick) begin
      if (FrameStart) begin
        RowOnes <= '0;
      end else if (state == COMMIT && !last_row) begin
        RowOnes <= '0;
      end else if (accept) begin
        RowOnes <= RowOnes + PopBits'(PixData);
      end
    end
  end
`else
  localparam int unused_pop_bits = PopBits;
`endif

endmodule

// File: tb/tb_pixel_row_packer.sv
// Scoreboard bench for pixel_row_packer: a frame-level model predicts handshake outputs
// and queues expected row writes; a monitor pops them whenever a write lands.
module tb_pixel_row_packer;
  localparam int NB = 4;
  localparam int NR = 2;
  localparam int AB = 1;
  localparam int PB = 3;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Tick;
  logic          FrameStart;
  logic          PixValid;
  logic          PixData;
  logic          PixReady;
  logic [NB-1:0] RegD;
  logic [AB-1:0] RegAddr;
  logic          RegWe;
  logic          FrameDone;
`ifdef PACK_POPCOUNT_EN
  logic [PB-1:0] RowOnes;
`endif

  pixel_row_packer #(
    .NrOfBits(NB),
    .NrOfRows(NR),
    .AddrBits(AB),
    .PopBits (PB)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Tick      (Tick),
    .FrameStart(FrameStart),
    .PixValid  (PixValid),
    .PixData   (PixData),
    .PixReady  (PixReady),
    .RegD      (RegD),
    .RegAddr   (RegAddr),
    .RegWe     (RegWe),
    .FrameDone (FrameDone)
`ifdef PACK_POPCOUNT_EN
    ,
    .RowOnes   (RowOnes)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int data;
    int addr;
    int ones;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Frame-level model: 0 idle, 1 collecting pixels, 2 row complete awaiting write, 3 frame done
  int  m_mode = 0;
  int  m_row  = 0;
  int  m_pix[$];
  int  last_word = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int row_word();
    int w = 0;
    foreach (m_pix[i]) w += m_pix[i] * (1 << (NB - 1 - i));
    return w;
  endfunction

  function automatic int row_ones();
    int s = 0;
    foreach (m_pix[i]) s += m_pix[i];
    return s;
  endfunction

  task automatic push_write();
    wr_t e;
    e.data = row_word();
    e.addr = m_row;
    e.ones = row_ones();
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: drive at negedge, check pre-edge outputs, advance the model.
  task automatic cyc(input bit t, input bit fs, input bit pv, input bit pd, input bit rst,
                     output bit acc);
    @(negedge Clock);
    Tick = t; FrameStart = fs; PixValid = pv; PixData = pd; Reset = rst;
    acc = 1'b0;
    if (rst) begin
      m_mode = 0;
      m_row  = 0;
      m_pix.delete();
    end
    #1;
    check("PixReady", 32'(PixReady), 32'(m_mode == 1 && !fs));
    check("RegWe", 32'(RegWe), 32'(m_mode == 2));
    check("FrameDone", 32'(FrameDone), 32'(m_mode == 3));
    check("RegAddr", 32'(RegAddr), 32'(m_row));
    if (rst) check("RegD_reset", 32'(RegD), 32'd0);
    if (m_mode == 3) check("RegD_done", 32'(RegD), 32'(last_word));
    if (!rst && t) begin
      if (fs) begin
        if (m_mode == 2) push_write();
        m_mode = 1;
        m_row  = 0;
        m_pix.delete();
      end else if (m_mode == 1) begin
        if (pv) begin
          acc = 1'b1;
          m_pix.push_back(int'(pd));
          if (m_pix.size() == NB) m_mode = 2;
        end
      end else if (m_mode == 2) begin
        push_write();
        if (m_row == NR - 1) begin
          last_word = row_word();
          m_mode = 3;
        end else begin
          m_row++;
          m_pix.delete();
          m_mode = 1;
        end
      end
    end
  endtask

  task automatic idle(input bit t, input bit fs, input bit rst);
    bit a;
    cyc(t, fs, 1'b0, 1'b0, rst, a);
  endtask

  // Present one row MSB-first; Tick only on every period-th cycle, PixValid held high.
  task automatic run_row(input logic [NB-1:0] bits, input int period);
    int  p = 0;
    int  k = 0;
    bit  a;
    while (p < NB && k < 200) begin
      cyc((k % period) == period - 1, 1'b0, 1'b1, bits[NB-1-p], 1'b0, a);
      if (a) p++;
      k++;
    end
    if (p < NB) begin
      n_cmp++; n_bad++;
      $display("FAIL run_row_timeout: got %0d pixels expected %0d", p, NB);
    end
  endtask

  // Write monitor: a write lands whenever RegWe and Tick are both high before an edge.
  always @(negedge Clock) begin
    wr_t e;
    #2;
    if (RegWe === 1'b1 && Tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got RegD=%0h RegAddr=%0d expected no write", RegD, RegAddr);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", 32'(RegD), 32'(e.data));
        check("wr_addr", 32'(RegAddr), 32'(e.addr));
`ifdef PACK_POPCOUNT_EN
        check("wr_ones", 32'(RowOnes), 32'(e.ones));
`endif
      end
    end
  end

  initial begin
    bit a;
    Tick = 0; FrameStart = 0; PixValid = 0; PixData = 0; Reset = 1;
    idle(1'b0, 1'b0, 1'b1);
    idle(1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0);
    // Basic frame: 1011 then 0110, then DONE holds until FrameStart.
    idle(1'b1, 1'b1, 1'b0);
    run_row(4'b1011, 1);
    idle(1'b1, 1'b0, 1'b0);
    run_row(4'b0110, 1);
    idle(1'b1, 1'b0, 1'b0);
    repeat (3) idle(1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
    // Sparse Tick: every third cycle, including a three-cycle COMMIT dwell.
    run_row(4'b1011, 3);
    for (int k = 0; k < 3; k++) cyc(k == 2, 1'b0, 1'b1, 1'b1, 1'b0, a);
    run_row(4'b0110, 3);
    for (int k = 0; k < 3; k++) cyc(k == 2, 1'b0, 1'b1, 1'b0, 1'b0, a);
    repeat (2) idle(1'b1, 1'b0, 1'b0);
    // Abort a partial row, then a clean row.
    idle(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, a);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, a);
    idle(1'b1, 1'b1, 1'b0);
    run_row(4'b1100, 1);
    idle(1'b1, 1'b0, 1'b0);
    // FrameStart together with a valid pixel: the pixel must not be counted.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, a);
    run_row(4'b1001, 1);
    idle(1'b1, 1'b0, 1'b0);
    // Reset in the middle of row 1's COMMIT: no write must appear.
    run_row(4'b0101, 1);
    idle(1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bit t, fs, pv, pd, rst;
      t   = ($urandom_range(0, 9) < 7);
      fs  = (m_mode == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) < 3);
      pv  = ($urandom_range(0, 9) < 6);
      pd  = 1'($urandom);
      rst = ($urandom_range(0, 999) < 5);
      cyc(t, fs, pv, pd, rst, a);
    end
    idle(1'b0, 1'b0, 1'b0);
    @(negedge Clock);
    #3;
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
